// File: rtl/a2d_spi_master_pkg.sv
// Shared types and constants for the slide-pot ADC SPI master.
// The ADC command word is {pad, channel, pad}; the result is 12 bits.
package a2d_spi_master_pkg;

  localparam int CH_W       = 3;
  localparam int RES_W      = 12;
  localparam int FRAME_BITS = 16;

  localparam int DIV_W_DFLT       = 5;
  localparam int FRONT_PORCH_DFLT = 10;
  localparam int GAP_DFLT         = 32;

  localparam logic [1:0]  CMD_PAD_HI = 2'b00;
  localparam logic [10:0] CMD_PAD_LO = 11'h000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FRAME1,
    ST_GAP,
    ST_FRAME2
  } state_t;

  function automatic logic [FRAME_BITS-1:0] make_cmd(input logic [CH_W-1:0] ch);
    return {CMD_PAD_HI, ch, CMD_PAD_LO};
  endfunction

endpackage

// File: rtl/a2d_spi_master_if.sv
// Sequencer handshake plus the four ADC SPI wires.
// The master modport is the view of the SPI master block itself.
interface a2d_spi_master_if;
  import a2d_spi_master_pkg::*;

  logic             strt_cnv;
  logic [CH_W-1:0]  chnnl;
  logic             cnv_cmplt;
  logic [RES_W-1:0] res;
  logic             a2d_SS_n;
  logic             SCLK;
  logic             MOSI;
  logic             MISO;

  modport master (
    input  strt_cnv,
    input  chnnl,
    input  MISO,
    output cnv_cmplt,
    output res,
    output a2d_SS_n,
    output SCLK,
    output MOSI
  );

  modport slave (
    output strt_cnv,
    output chnnl,
    output MISO,
    input  cnv_cmplt,
    input  res,
    input  a2d_SS_n,
    input  SCLK,
    input  MOSI
  );

endinterface

// File: rtl/a2d_spi_master_frame.sv
// One 16-bit SPI frame: divider-derived SCLK, chip select, MOSI shift-out
// and MISO capture. done flags the edge on which SS_n returns high.
module a2d_spi_master_frame
  import a2d_spi_master_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DFLT,
  parameter int FRONT_PORCH = FRONT_PORCH_DFLT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] tx_word,
  input  logic                  miso,
  output logic                  done,
  output logic [RES_W-1:0]      rx_word,
  output logic                  ss_n,
  output logic                  sclk,
  output logic                  mosi
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam logic [DIV_W-1:0] PRELOAD = DIV_W'((2 ** DIV_W) - FRONT_PORCH);
  localparam logic [DIV_W-1:0] RISE_PT = DIV_W'((2 ** (DIV_W - 1)) - 1);
  localparam logic [DIV_W-1:0] FALL_PT = '1;

  logic [DIV_W-1:0]      div;
  logic [FRAME_BITS-1:0] shift;
  logic [CNT_W-1:0]      rise_cnt;
  logic                  miso_q;
  logic                  rise_pt;
  logic                  fall_pt;
  logic                  last_fall;

  assign rise_pt   = !ss_n && (div == RISE_PT);
  assign fall_pt   = !ss_n && (div == FALL_PT);
  assign last_fall = fall_pt && (rise_cnt == CNT_W'(FRAME_BITS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_n     <= 1'b1;
      div      <= PRELOAD;
      shift    <= '0;
      rise_cnt <= '0;
      miso_q   <= 1'b0;
    end else if (start && ss_n) begin
      ss_n     <= 1'b0;
      div      <= PRELOAD;
      shift    <= tx_word;
      rise_cnt <= '0;
    end else if (!ss_n) begin
      // The closing fall point reloads the divider so SCLK never drops.
      if (last_fall) begin
        ss_n <= 1'b1;
        div  <= PRELOAD;
      end else begin
        div <= div + 1'b1;
      end
      if (rise_pt) begin
        miso_q   <= miso;
        rise_cnt <= rise_cnt + 1'b1;
      end
      // The first fall of a frame only exposes the MSB already on MOSI.
      if (fall_pt && (rise_cnt != '0)) begin
        shift <= {shift[FRAME_BITS-2:0], miso_q};
      end
    end
  end

  assign sclk    = div[DIV_W-1];
  assign mosi    = shift[FRAME_BITS-1];
  assign done    = last_fall;
  assign rx_word = {shift[RES_W-2:0], miso_q};

endmodule

// File: rtl/a2d_spi_master.sv
// Two-frame ADC conversion sequencer: command frame, chip-select gap,
// result frame, then a sticky completion flag with the captured result.
module a2d_spi_master
  import a2d_spi_master_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DFLT,
  parameter int FRONT_PORCH = FRONT_PORCH_DFLT,
  parameter int GAP         = GAP_DFLT
) (
  input logic              clk,
  input logic              rst_n,
  a2d_spi_master_if.master bus
);

  localparam int GAP_CNT_W = $clog2(GAP + 1);

  state_t                state;
  logic [CH_W-1:0]       ch_lat;
  logic [GAP_CNT_W-1:0]  gap_cnt;
  logic [RES_W-1:0]      res;
  logic                  cnv_cmplt;
  logic                  gap_end;
  logic                  frame_start;
  logic                  frame_done;
  logic [FRAME_BITS-1:0] tx_word;
  logic [RES_W-1:0]      rx_word;
  logic                  ss_n;
  logic                  sclk;
  logic                  mosi;

  assign gap_end     = (state == ST_GAP) && (gap_cnt == GAP_CNT_W'(GAP - 1));
  assign frame_start = ((state == ST_IDLE) && bus.strt_cnv) || gap_end;
  // Frame 1 loads straight from chnnl on the accepting edge; frame 2 repeats the latch.
  assign tx_word     = make_cmd((state == ST_IDLE) ? bus.chnnl : ch_lat);

  a2d_spi_master_frame #(
    .DIV_W       (DIV_W),
    .FRONT_PORCH (FRONT_PORCH)
  ) u_frame (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (frame_start),
    .tx_word (tx_word),
    .miso    (bus.MISO),
    .done    (frame_done),
    .rx_word (rx_word),
    .ss_n    (ss_n),
    .sclk    (sclk),
    .mosi    (mosi)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ch_lat    <= '0;
      gap_cnt   <= '0;
      res       <= '0;
      cnv_cmplt <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.strt_cnv) begin
            state     <= ST_FRAME1;
            ch_lat    <= bus.chnnl;
            cnv_cmplt <= 1'b0;
          end
        end
        ST_FRAME1: begin
          if (frame_done) begin
            state   <= ST_GAP;
            gap_cnt <= '0;
          end
        end
        ST_GAP: begin
          if (gap_end) begin
            state <= ST_FRAME2;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        ST_FRAME2: begin
          if (frame_done) begin
            state     <= ST_IDLE;
            res       <= rx_word;
            cnv_cmplt <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cnv_cmplt = cnv_cmplt;
  assign bus.res       = res;
  assign bus.a2d_SS_n  = ss_n;
  assign bus.SCLK      = sclk;
  assign bus.MOSI      = mosi;

endmodule

// File: tb/tb_a2d_spi_master.sv
// Scoreboard bench for a2d_spi_master with a behavioural ADC128S-style slave.
module tb_a2d_spi_master;

  localparam int SPAN    = 522;
  localparam int PORCH   = 10;
  localparam int GAPLEN  = 32;
  localparam int CNV_LAT = 2 * SPAN + GAPLEN;

  typedef struct {
    logic [11:0] res;
    int          e0;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;

  exp_t       res_q[$];
  logic [2:0] cmd_q[$];

  a2d_spi_master_if bus();

  a2d_spi_master dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ADC slave: result of the channel commanded in the previous frame, 4 leading zeros
  logic [11:0] adc_val [8];
  int          miso_mode = 0;
  logic [2:0]  adc_ch = 3'd0;
  logic [15:0] adc_rx = 16'h0;
  logic [15:0] adc_tx = 16'h0;
  int          adc_bit = 0;

  initial forever begin
    @(negedge bus.a2d_SS_n);
    adc_tx  = {4'h0, adc_val[adc_ch]};
    adc_bit = 0;
    adc_rx  = 16'h0;
  end
  initial forever begin
    @(posedge bus.a2d_SS_n);
    adc_ch = adc_rx[13:11];
  end
  initial forever begin
    @(posedge bus.SCLK);
    if (!bus.a2d_SS_n) adc_rx = {adc_rx[14:0], bus.MOSI};
  end
  initial begin
    bus.MISO = 1'b0;
    forever begin
      @(negedge bus.SCLK);
      if (!bus.a2d_SS_n && adc_bit < 16) begin
        if (miso_mode == 1)      bus.MISO = 1'b1;
        else if (miso_mode == 2) bus.MISO = 1'b0;
        else                     bus.MISO = adc_tx[15 - adc_bit];
        adc_bit++;
      end
    end
  end

  // Frame monitor: edge counts, porch, span, gap, and the command on MOSI
  logic        ss_prev = 1'b1;
  logic        sclk_prev = 1'b1;
  int          falls = 0;
  int          rises = 0;
  int          ss_fall_cyc = 0;
  int          ss_rise_cyc = 0;
  bit          fr2 = 1'b0;
  logic [15:0] mosi_w = 16'h0;

  always @(negedge clk) begin
    if (!chk_en || !rst_n) begin
      fr2       <= 1'b0;
      ss_prev   <= 1'b1;
      sclk_prev <= 1'b1;
      falls     <= 0;
      rises     <= 0;
    end else begin
      if (ss_prev && !bus.a2d_SS_n) begin
        ss_fall_cyc <= cyc;
        falls       <= 0;
        rises       <= 0;
        if (fr2) check("gap_len", 32'(cyc - ss_rise_cyc), GAPLEN);
      end else if (!ss_prev && !bus.a2d_SS_n) begin
        if (sclk_prev && !bus.SCLK) begin
          falls <= falls + 1;
          if (falls == 0) check("front_porch", 32'(cyc - ss_fall_cyc), PORCH);
        end
        if (!sclk_prev && bus.SCLK) begin
          rises  <= rises + 1;
          mosi_w <= {mosi_w[14:0], bus.MOSI};
        end
      end else if (!ss_prev && bus.a2d_SS_n) begin
        check("sclk_falls", 32'(falls), 16);
        check("sclk_rises", 32'(rises), 16);
        check("ss_low_span", 32'(cyc - ss_fall_cyc), SPAN);
        check("sclk_high_at_frame_end", 32'(bus.SCLK), 1);
        check("cmd_expected", 32'(cmd_q.size() != 0), 1);
        if (cmd_q.size() != 0) begin
          check("mosi_cmd", 32'(mosi_w), 32'({2'b00, cmd_q[0], 11'h000}));
          void'(cmd_q.pop_front());
        end
        ss_rise_cyc <= cyc;
        fr2         <= !fr2;
      end
      ss_prev   <= bus.a2d_SS_n;
      sclk_prev <= bus.SCLK;
    end
  end

  // Completion monitor: pops the scoreboard on each cnv_cmplt rise
  logic cmplt_prev = 1'b0;

  always @(negedge clk) begin
    if (rst_n && bus.cnv_cmplt && !cmplt_prev) begin
      check("cmplt_expected", 32'(res_q.size() != 0), 1);
      if (res_q.size() != 0) begin
        check("res", 32'(bus.res), 32'(res_q[0].res));
        check("cnv_latency", 32'(cyc - res_q[0].e0), CNV_LAT);
        void'(res_q.pop_front());
      end
    end
    cmplt_prev <= rst_n && bus.cnv_cmplt;
  end

  function automatic logic [11:0] model_res(input logic [2:0] ch);
    if (miso_mode == 1) return 12'hFFF;
    if (miso_mode == 2) return 12'h000;
    return adc_val[ch];
  endfunction

  task automatic expect_conv(input logic [2:0] ch, input int e0);
    exp_t x;
    x.res = model_res(ch);
    x.e0  = e0;
    res_q.push_back(x);
    cmd_q.push_back(ch);
    cmd_q.push_back(ch);
  endtask

  task automatic wait_cmplt(input string name);
    int t;
    t = 0;
    while (!bus.cnv_cmplt && t < 1200) begin
      @(negedge clk);
      t++;
    end
    check(name, 32'(bus.cnv_cmplt), 1);
  endtask

  task automatic conv(input logic [2:0] ch, input bit disturb);
    bus.chnnl    = ch;
    bus.strt_cnv = 1'b1;
    @(negedge clk);
    bus.strt_cnv = 1'b0;
    check("ss_low_after_accept", 32'(bus.a2d_SS_n), 0);
    check("cmplt_cleared_on_accept", 32'(bus.cnv_cmplt), 0);
    expect_conv(ch, cyc);
    if (disturb) begin
      repeat (100) @(negedge clk);
      bus.strt_cnv = 1'b1;
      bus.chnnl    = 3'b010;
      @(negedge clk);
      bus.strt_cnv = 1'b0;
    end
    wait_cmplt("cmplt_timeout");
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    int e0;
    logic [2:0] rch;
    bus.strt_cnv = 1'b0;
    bus.chnnl    = 3'd0;
    for (int i = 0; i < 8; i++) adc_val[i] = 12'h000;

    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_ss_n", 32'(bus.a2d_SS_n), 1);
    check("rst_sclk", 32'(bus.SCLK), 1);
    check("rst_mosi", 32'(bus.MOSI), 0);
    check("rst_cmplt", 32'(bus.cnv_cmplt), 0);
    check("rst_res", 32'(bus.res), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Abort mid frame 1 with an asynchronous reset
    bus.chnnl    = 3'd6;
    bus.strt_cnv = 1'b1;
    @(negedge clk);
    bus.strt_cnv = 1'b0;
    check("abort_ss_low", 32'(bus.a2d_SS_n), 0);
    repeat (50) @(negedge clk);
    check("abort_sclk_low_before", 32'(bus.SCLK), 0);
    #1 rst_n = 1'b0;
    #1;
    check("abort_ss_n", 32'(bus.a2d_SS_n), 1);
    check("abort_sclk", 32'(bus.SCLK), 1);
    check("abort_res", 32'(bus.res), 0);
    check("abort_cmplt", 32'(bus.cnv_cmplt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_after_abort", 32'(bus.a2d_SS_n), 1);
    chk_en = 1'b1;
    @(negedge clk);

    // Channel command and result
    adc_val[5] = 12'hA5C;
    adc_val[2] = 12'h222;
    conv(3'd5, 1'b0);
    repeat (30) @(negedge clk);
    check("res_hold", 32'(bus.res), 32'h0A5C);
    check("cmplt_sticky", 32'(bus.cnv_cmplt), 1);

    // Ignore strt_cnv and chnnl changes while busy
    conv(3'd5, 1'b1);
    repeat (5) @(negedge clk);

    // Channel sweep
    for (int ch = 0; ch < 8; ch++) adc_val[ch] = 12'(12'h100 * ch + ch);
    for (int ch = 0; ch < 8; ch++) conv(3'(ch), 1'b0);

    // Random channels and values
    for (int k = 0; k < 4; k++) begin
      rch = 3'($urandom_range(0, 7));
      adc_val[rch] = 12'($urandom);
      repeat ($urandom_range(1, 20)) @(negedge clk);
      conv(rch, 1'b0);
    end

    // MISO extremes
    miso_mode = 1;
    conv(3'd3, 1'b0);
    miso_mode = 2;
    conv(3'd4, 1'b0);
    miso_mode = 0;

    // strt_cnv held high: restart one clock after completion
    adc_val[1] = 12'h3C1;
    adc_val[6] = 12'h6E6;
    bus.chnnl    = 3'd1;
    bus.strt_cnv = 1'b1;
    @(negedge clk);
    e0 = cyc;
    expect_conv(3'd1, e0);
    bus.chnnl = 3'd6;
    wait_cmplt("b2b_first_cmplt");
    check("b2b_ss_high_at_cmplt", 32'(bus.a2d_SS_n), 1);
    expect_conv(3'd6, cyc + 1);
    @(negedge clk);
    bus.strt_cnv = 1'b0;
    check("b2b_restart_ss_low", 32'(bus.a2d_SS_n), 0);
    check("b2b_cmplt_cleared", 32'(bus.cnv_cmplt), 0);
    wait_cmplt("b2b_second_cmplt");

    repeat (10) @(negedge clk);
    check("res_queue_drained", 32'(res_q.size()), 0);
    check("cmd_queue_drained", 32'(cmd_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
